ibex_register_file_mp: RTL and testbench

Flip-flop register file with a parametrised number of read ports, two prioritised write ports, optional same-cycle write-to-read bypass and a hardware wipe sequencer that clears the whole file one word per cycle. It sits between the ID/EX read logic and the write-back stages of cores that retire two results per cycle, such as a split ALU and LSU write-back. It replaces the single-write-port register file in those configurations.

---
 rtl/ibex_register_file_mp.sv | 122 ++++++++++++
 tb/tb_ibex_register_file_mp.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ibex_register_file_mp.sv
// Flip-flop register file: N combinational read ports, two prioritised write
// ports (B wins), optional write-to-read bypass and a one-word-per-cycle wipe.
module ibex_register_file_mp #(
  parameter bit                    RV32E        = 1'b0,
  parameter int unsigned           DataWidth    = 32,
  parameter int unsigned           NumReadPorts = 3,
  parameter bit                    WriteBypass  = 1'b1,
  parameter logic [DataWidth-1:0]  WordZeroVal  = '0
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [5*NumReadPorts-1:0]         raddr_i,
  output logic [DataWidth*NumReadPorts-1:0] rdata_o,
  input  logic [4:0]                        waddr_a_i,
  input  logic [DataWidth-1:0]              wdata_a_i,
  input  logic                              we_a_i,
  input  logic [4:0]                        waddr_b_i,
  input  logic [DataWidth-1:0]              wdata_b_i,
  input  logic                              we_b_i,
  input  logic                              wipe_req_i,
  output logic                              wipe_busy_o,
  output logic                              wipe_done_o,
  output logic                              err_o
);

  localparam int unsigned ADDR_WIDTH = RV32E ? 4 : 5;
  localparam int unsigned NUM_WORDS  = 2 ** ADDR_WIDTH;

  typedef enum logic [1:0] {IDLE, WIPE, DONE} wipe_state_e;

  wipe_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0] wipe_cnt_q;
  logic [DataWidth-1:0]  mem_q [1:NUM_WORDS-1];
  logic [DataWidth-1:0]  words [NUM_WORDS];
  logic                  err_q;

  logic [ADDR_WIDTH-1:0] addr_a, addr_b;
  logic                  wipe_active, wr_a, wr_b, collision, dropped;

  // Upper address bits are deliberately ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{raddr_i, waddr_a_i, waddr_b_i};

  assign addr_a      = waddr_a_i[ADDR_WIDTH-1:0];
  assign addr_b      = waddr_b_i[ADDR_WIDTH-1:0];
  assign wipe_active = (state_q == WIPE);
  assign wr_a        = we_a_i && !wipe_active && (addr_a != '0);
  assign wr_b        = we_b_i && !wipe_active && (addr_b != '0);
  assign collision   = wr_a && wr_b && (addr_a == addr_b);
  assign dropped     = wipe_active && (we_a_i || we_b_i);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (wipe_req_i) state_d = WIPE;
      WIPE:    if (wipe_cnt_q == ADDR_WIDTH'(NUM_WORDS - 1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wipe_cnt_q <= '0;
    end else if (state_q == IDLE && wipe_req_i) begin
      wipe_cnt_q <= ADDR_WIDTH'(1);
    end else if (wipe_active) begin
      wipe_cnt_q <= wipe_cnt_q + ADDR_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) err_q <= 1'b0;
    else       err_q <= collision || dropped;
  end

  // Wipe owns the array while active; otherwise port B overrides port A.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 1; i < NUM_WORDS; i++) mem_q[i] <= WordZeroVal;
    end else begin
      for (int i = 1; i < NUM_WORDS; i++) begin
        if (wipe_active) begin
          if (wipe_cnt_q == ADDR_WIDTH'(i)) mem_q[i] <= WordZeroVal;
        end else if (wr_b && addr_b == ADDR_WIDTH'(i)) begin
          mem_q[i] <= wdata_b_i;
        end else if (wr_a && addr_a == ADDR_WIDTH'(i)) begin
          mem_q[i] <= wdata_a_i;
        end
      end
    end
  end

  assign words[0] = WordZeroVal;
  for (genvar w = 1; w < NUM_WORDS; w++) begin : g_words
    assign words[w] = mem_q[w];
  end

  for (genvar p = 0; p < NumReadPorts; p++) begin : g_read
    logic [ADDR_WIDTH-1:0] ra;
    logic [DataWidth-1:0]  rd;
    assign ra = raddr_i[5*p +: ADDR_WIDTH];
    always_comb begin
      rd = words[ra];
      if (WriteBypass && ra != '0) begin
        if (wr_b && addr_b == ra)      rd = wdata_b_i;
        else if (wr_a && addr_a == ra) rd = wdata_a_i;
      end
    end
    assign rdata_o[DataWidth*p +: DataWidth] = rd;
  end

  assign wipe_busy_o = (state_q == WIPE);
  assign wipe_done_o = (state_q == DONE);
  assign err_o       = err_q;

endmodule

// File: tb/tb_ibex_register_file_mp.sv
// Bench for ibex_register_file_mp: default, no-bypass and RV32E instances
// share one stimulus stream; read expectations flow through a queue.
module tb_ibex_register_file_mp;
  localparam int DW = 32;
  localparam int NP = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic [5*NP-1:0]  raddr;
  logic [DW*NP-1:0] rdata, rdata_nb, rdata_e;
  logic [4:0]       waddr_a, waddr_b;
  logic [DW-1:0]    wdata_a, wdata_b;
  logic             we_a, we_b, wipe_req;
  logic             busy, done, err, busy_nb, done_nb, err_nb, busy_e, done_e, err_e;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] ref_mem [32];
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  ibex_register_file_mp dut (
    .clk_i(clk), .rst_i(rst), .raddr_i(raddr), .rdata_o(rdata),
    .waddr_a_i(waddr_a), .wdata_a_i(wdata_a), .we_a_i(we_a),
    .waddr_b_i(waddr_b), .wdata_b_i(wdata_b), .we_b_i(we_b),
    .wipe_req_i(wipe_req), .wipe_busy_o(busy), .wipe_done_o(done), .err_o(err)
  );

  ibex_register_file_mp #(.WriteBypass(1'b0)) dut_nb (
    .clk_i(clk), .rst_i(rst), .raddr_i(raddr), .rdata_o(rdata_nb),
    .waddr_a_i(waddr_a), .wdata_a_i(wdata_a), .we_a_i(we_a),
    .waddr_b_i(waddr_b), .wdata_b_i(wdata_b), .we_b_i(we_b),
    .wipe_req_i(wipe_req), .wipe_busy_o(busy_nb), .wipe_done_o(done_nb), .err_o(err_nb)
  );

  ibex_register_file_mp #(.RV32E(1'b1)) dut_e (
    .clk_i(clk), .rst_i(rst), .raddr_i(raddr), .rdata_o(rdata_e),
    .waddr_a_i(waddr_a), .wdata_a_i(wdata_a), .we_a_i(we_a),
    .waddr_b_i(waddr_b), .wdata_b_i(wdata_b), .we_b_i(we_b),
    .wipe_req_i(wipe_req), .wipe_busy_o(busy_e), .wipe_done_o(done_e), .err_o(err_e)
  );

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic sb_check(input string tag, input logic [DW-1:0] got);
    logic [DW-1:0] e;
    if (exp_q.size() == 0) e = ~got;
    else e = exp_q.pop_front();
    check(tag, got, e);
  endtask

  task automatic push3(input logic [DW-1:0] e0, input logic [DW-1:0] e1, input logic [DW-1:0] e2);
    exp_q.push_back(e0);
    exp_q.push_back(e1);
    exp_q.push_back(e2);
  endtask

  task automatic check_reads(input string tag, input logic [DW*NP-1:0] bus, input int n);
    for (int p = 0; p < n; p++) sb_check($sformatf("%s p%0d", tag, p), bus[DW*p +: DW]);
  endtask

  task automatic check_flag(input string tag, input logic got, input logic exp);
    check(tag, {31'b0, got}, {31'b0, exp});
  endtask

  task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2);
    raddr = {a2, a1, a0};
  endtask

  task automatic idle_wr();
    we_a = 1'b0; waddr_a = '0; wdata_a = '0;
    we_b = 1'b0; waddr_b = '0; wdata_b = '0;
    wipe_req = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bcnt, bcnt_e, done_at, done_at_e;
    logic [DW-1:0] e3, e31, e2;
    rst = 1'b1;
    idle_wr();
    set_rd(0, 0, 0);
    for (int i = 0; i < 32; i++) ref_mem[i] = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check_flag("rst busy", busy, 1'b0);
    check_flag("rst done", done, 1'b0);
    check_flag("rst err", err, 1'b0);
    check_flag("rst busy_e", busy_e, 1'b0);

    // Every address on every port reads zero after reset
    for (int a = 0; a < 32; a++) begin
      @(negedge clk);
      set_rd(5'(a), 5'(a), 5'(a));
      push3('0, '0, '0);
      #1 check_reads($sformatf("rst rd x%0d", a), rdata, NP);
    end

    // Dual write to different words, with same-cycle read
    @(negedge clk);
    we_a = 1'b1; waddr_a = 5'd5; wdata_a = 32'h1234;
    we_b = 1'b1; waddr_b = 5'd6; wdata_b = 32'hABCD;
    set_rd(5, 6, 0);
    push3(32'h1234, 32'hABCD, '0);
    #1 check_reads("bypass", rdata, NP);
    push3(ref_mem[5], ref_mem[6], '0);
    check_reads("nobypass old", rdata_nb, NP);
    ref_mem[5] = 32'h1234;
    ref_mem[6] = 32'hABCD;
    @(negedge clk);
    idle_wr();
    push3(ref_mem[5], ref_mem[6], '0);
    #1 check_reads("stored", rdata, NP);
    push3(ref_mem[5], ref_mem[6], '0);
    check_reads("nobypass new", rdata_nb, NP);
    check_flag("dual err", err, 1'b0);

    // Same-address collision: B wins, err pulses one cycle
    @(negedge clk);
    we_a = 1'b1; waddr_a = 5'd7; wdata_a = 32'h1;
    we_b = 1'b1; waddr_b = 5'd7; wdata_b = 32'h2;
    set_rd(7, 0, 0);
    push3(32'h2, '0, '0);
    #1 check_reads("coll bypass", rdata, NP);
    ref_mem[7] = 32'h2;
    @(negedge clk);
    idle_wr();
    set_rd(7, 5, 6);
    push3(ref_mem[7], ref_mem[5], ref_mem[6]);
    #1 check_reads("coll stored", rdata, NP);
    check_flag("coll err", err, 1'b1);
    @(negedge clk);
    #1 check_flag("coll err gone", err, 1'b0);

    // Writes to x0 are discarded, never bypassed, never flagged
    @(negedge clk);
    we_a = 1'b1; waddr_a = 5'd0; wdata_a = 32'h55;
    we_b = 1'b1; waddr_b = 5'd0; wdata_b = 32'h66;
    set_rd(0, 0, 0);
    push3('0, '0, '0);
    #1 check_reads("x0 wr cycle", rdata, NP);
    @(negedge clk);
    idle_wr();
    push3('0, '0, '0);
    #1 check_reads("x0 after", rdata, NP);
    check_flag("x0 err", err, 1'b0);

    // Fill x1..x31 with nonzero data and read it all back
    for (int i = 1; i < 32; i += 2) begin
      @(negedge clk);
      idle_wr();
      we_a = 1'b1; waddr_a = 5'(i); wdata_a = $urandom() | 32'h1;
      ref_mem[i] = wdata_a;
      if (i + 1 < 32) begin
        we_b = 1'b1; waddr_b = 5'(i + 1); wdata_b = $urandom_range(1, 32'h7FFF_FFFF);
        ref_mem[i + 1] = wdata_b;
      end
    end
    @(negedge clk);
    idle_wr();
    for (int a = 1; a < 32; a++) begin
      set_rd(5'(a), 5'(a), 5'(a));
      push3(ref_mem[a], ref_mem[a], ref_mem[a]);
      #1 check_reads($sformatf("fill x%0d", a), rdata, NP);
      @(negedge clk);
    end

    // Wipe: request in cycle 0, write attempt in cycle 10, write in DONE cycle
    wipe_req = 1'b1;
    set_rd(3, 31, 9);
    push3(ref_mem[3], ref_mem[31], ref_mem[9]);
    #1 check_reads("wipe c0", rdata, NP);
    check_flag("wipe c0 busy", busy, 1'b0);
    for (int c = 1; c <= 33; c++) begin
      @(negedge clk);
      idle_wr();
      if (c == 10) begin
        we_a = 1'b1; waddr_a = 5'd9; wdata_a = 32'hFF;
      end
      if (c == 32) begin
        we_a = 1'b1; waddr_a = 5'd10; wdata_a = 32'h5A5A;
      end
      e3  = (c >= 4)  ? '0 : ref_mem[3];
      e31 = (c >= 32) ? '0 : ref_mem[31];
      e2  = (c >= 10) ? '0 : ref_mem[9];
      if (c <= 31) begin
        set_rd(3, 31, 9);
        push3(e3, e31, e2);
      end else if (c == 32) begin
        set_rd(3, 31, 10);
        push3(e3, e31, 32'h5A5A);
      end else begin
        set_rd(10, 9, 3);
        push3(32'h5A5A, '0, '0);
      end
      #1 check_reads($sformatf("wipe c%0d", c), rdata, NP);
      check_flag($sformatf("wipe busy c%0d", c), busy, (c >= 1 && c <= 31));
      check_flag($sformatf("wipe done c%0d", c), done, (c == 32));
      check_flag($sformatf("wipe err c%0d", c), err, (c == 11));
      check_flag($sformatf("wipe_e busy c%0d", c), busy_e, (c >= 1 && c <= 15));
      check_flag($sformatf("wipe_e done c%0d", c), done_e, (c == 16));
    end
    for (int i = 0; i < 32; i++) ref_mem[i] = '0;
    ref_mem[10] = 32'h5A5A;

    // Reset in cycle 12 of a wipe
    @(negedge clk);
    idle_wr();
    we_a = 1'b1; waddr_a = 5'd20; wdata_a = 32'h777;
    we_b = 1'b1; waddr_b = 5'd21; wdata_b = 32'h888;
    @(negedge clk);
    idle_wr();
    wipe_req = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      idle_wr();
    end
    #1 check_flag("pre-rst busy", busy, 1'b1);
    rst = 1'b1;
    #1;
    check_flag("mid rst busy", busy, 1'b0);
    check_flag("mid rst done", done, 1'b0);
    check_flag("mid rst err", err, 1'b0);
    check_flag("mid rst busy_e", busy_e, 1'b0);
    for (int i = 0; i < 32; i++) ref_mem[i] = '0;
    set_rd(20, 21, 10);
    push3(ref_mem[20], ref_mem[21], ref_mem[10]);
    #1 check_reads("mid rst rd", rdata, NP);
    @(negedge clk);
    rst = 1'b0;

    // Fresh wipe after reset must run its full length
    @(negedge clk);
    wipe_req = 1'b1;
    bcnt = 0; bcnt_e = 0; done_at = -1; done_at_e = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      idle_wr();
      #1;
      if (busy) bcnt++;
      if (busy_e) bcnt_e++;
      if (done && done_at < 0) done_at = c;
      if (done_e && done_at_e < 0) done_at_e = c;
    end
    check("rewipe busy cycles", 32'(bcnt), 32'd31);
    check("rewipe done cycle", 32'(done_at), 32'd32);
    check("rewipe_e busy cycles", 32'(bcnt_e), 32'd15);
    check("rewipe_e done cycle", 32'(done_at_e), 32'd16);

    // Back in IDLE, writes land normally
    @(negedge clk);
    we_a = 1'b1; waddr_a = 5'd12; wdata_a = 32'hC0DE;
    set_rd(12, 20, 0);
    push3(32'hC0DE, '0, '0);
    #1 check_reads("idle wr bypass", rdata, NP);
    @(negedge clk);
    idle_wr();
    push3(32'hC0DE, '0, '0);
    #1 check_reads("idle wr stored", rdata, NP);
    check_flag("idle err", err, 1'b0);

    check("sb drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
